// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared types and the round-robin selection function for the SDRAM read arbiters.
// The function works on the widest supported client count and is narrowed by its callers.
package jtframe_sdram_arb_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

    localparam int MAX_CLIENTS = 8;
    localparam int CLW         = $clog2(MAX_CLIENTS);

    typedef struct packed {
        logic           found;
        logic [CLW-1:0] idx;
    } pick_t;

    // First set bit of miss at or after ptr, wrapping modulo n.
    function automatic pick_t rr_pick(input logic [MAX_CLIENTS-1:0] miss,
                                      input logic [CLW-1:0]         ptr,
                                      input int                     n);
        pick_t p;
        int    idx;
        p.found = 1'b0;
        p.idx   = '0;
        for (int k = 0; k < MAX_CLIENTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !p.found && miss[idx[CLW-1:0]]) begin
                p.found = 1'b1;
                p.idx   = CLW'(idx);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin priority encoder over CLIENTS request lines.
module jtframe_rr_pick
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int CLIENTS = 4
)(
    input  logic [CLIENTS-1:0]         miss,
    input  logic [$clog2(CLIENTS)-1:0] ptr,
    output logic                       found,
    output logic [$clog2(CLIENTS)-1:0] grant
);
    localparam int IW = $clog2(CLIENTS);

    pick_t pick;

    always_comb begin
        pick  = rr_pick(MAX_CLIENTS'(miss), CLW'(ptr), CLIENTS);
        found = pick.found;
        grant = IW'(pick.idx);
    end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter sharing one SDRAM read port among ROM clients,
// with a one-word hit cache per client and traffic blocked during ROM download.
module jtframe_sdram_arb
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int CLIENTS = 4,
    parameter int AW      = 22,
    parameter int TOUT    = 255
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  downloading,
    input  logic [CLIENTS-1:0]    cl_req,
    input  logic [CLIENTS*AW-1:0] cl_addr,
    output logic [CLIENTS*32-1:0] cl_data,
    output logic [CLIENTS-1:0]    cl_ok,
    output logic                  sdram_req,
    output logic [AW-1:0]         sdram_addr,
    input  logic                  sdram_ack,
    input  logic                  data_rdy,
    input  logic [31:0]           data_read,
    output logic                  busy
);
    localparam int IW = $clog2(CLIENTS);
    localparam int TW = $clog2(TOUT+1);

    state_t             state, st_nxt;
    logic [IW-1:0]      ptr, grant, pick;
    logic               found;
    logic [CLIENTS-1:0] miss;
    logic [CLIENTS-1:0] cache_valid;
    logic [AW-1:0]      cache_addr [CLIENTS];
    logic [TW-1:0]      cnt;
    logic               do_grant, do_ack, do_rdy, do_tout;

    always_comb begin
        cl_ok = '0;
        for (int i = 0; i < CLIENTS; i++)
            cl_ok[i] = cl_req[i] & cache_valid[i] & (cache_addr[i] == cl_addr[i*AW +: AW]);
        miss = cl_req & ~cl_ok;
    end

    jtframe_rr_pick #(.CLIENTS(CLIENTS)) u_pick (
        .miss  (miss),
        .ptr   (ptr),
        .found (found),
        .grant (pick)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= st_nxt;
    end

    // data_rdy is only honoured in WAIT_RDY, so a stray rdy coincident with ack is dropped
    always_comb begin
        st_nxt   = state;
        do_grant = 1'b0;
        do_ack   = 1'b0;
        do_rdy   = 1'b0;
        do_tout  = 1'b0;
        case (state)
            IDLE:
                if (!downloading && found) begin
                    do_grant = 1'b1;
                    st_nxt   = WAIT_ACK;
                end
            WAIT_ACK:
                if (sdram_ack) begin
                    do_ack = 1'b1;
                    st_nxt = WAIT_RDY;
                end
            WAIT_RDY:
                if (data_rdy) begin
                    do_rdy = 1'b1;
                    st_nxt = IDLE;
                end else if (cnt == TW'(TOUT-1)) begin
                    do_tout = 1'b1;
                    st_nxt  = WAIT_ACK;
                end
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            grant       <= '0;
            sdram_req   <= 1'b0;
            sdram_addr  <= '0;
            cnt         <= '0;
            cl_data     <= '0;
            cache_valid <= '0;
            for (int i = 0; i < CLIENTS; i++) cache_addr[i] <= '0;
        end else begin
            if (do_grant) begin
                sdram_addr <= cl_addr[pick*AW +: AW];
                grant      <= pick;
                sdram_req  <= 1'b1;
            end
            if (do_ack) begin
                sdram_req <= 1'b0;
                cnt       <= '0;
            end
            if (state == WAIT_RDY && !do_rdy) cnt <= cnt + 1'b1;
            if (do_tout) begin
                sdram_req <= 1'b1;
                cnt       <= '0;
            end
            if (do_rdy) begin
                ptr <= (grant == IW'(CLIENTS-1)) ? '0 : grant + 1'b1;
                if (!downloading) begin
                    cl_data[grant*32 +: 32] <= data_read;
                    cache_addr[grant]       <= sdram_addr;
                    cache_valid[grant]      <= 1'b1;
                end
            end
            if (downloading) cache_valid <= '0;
        end
    end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Directed self-checking bench for jtframe_sdram_arb with a hand-driven SDRAM controller.
module tb_jtframe_sdram_arb;
    localparam int CLIENTS = 4;
    localparam int AW      = 22;
    localparam int TOUT    = 255;

    logic                  clk, rst, downloading;
    logic [CLIENTS-1:0]    cl_req;
    logic [CLIENTS*AW-1:0] cl_addr;
    logic [CLIENTS*32-1:0] cl_data;
    logic [CLIENTS-1:0]    cl_ok;
    logic                  sdram_req, sdram_ack, data_rdy, busy;
    logic [AW-1:0]         sdram_addr;
    logic [31:0]           data_read;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [3:0]  req;
        logic [21:0] a0, a1, a2, a3;
        logic [3:0]  exp_ok;
    } vec_t;

    vec_t vecs [8];

    jtframe_sdram_arb #(.CLIENTS(CLIENTS), .AW(AW), .TOUT(TOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .cl_req      (cl_req),
        .cl_addr     (cl_addr),
        .cl_data     (cl_data),
        .cl_ok       (cl_ok),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [21:0] a0, input logic [21:0] a1,
                                 input logic [21:0] a2, input logic [21:0] a3);
        cl_addr = {a3, a2, a1, a0};
        cl_req  = req;
    endtask

    task automatic set_addr(input int i, input logic [21:0] a);
        cl_addr[i*AW +: AW] = a;
    endtask

    function automatic logic [31:0] data_of(input int i);
        return cl_data[i*32 +: 32];
    endfunction

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            if (sdram_req) got = 1'b1;
            else tick();
        end
    endtask

    task automatic pulse_ack();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
    endtask

    task automatic pulse_rdy(input logic [31:0] d);
        data_rdy  = 1'b1;
        data_read = d;
        tick();
        data_rdy  = 1'b0;
    endtask

    task automatic serve(input logic [21:0] exp_addr, input logic [31:0] d, input string name);
        bit got;
        wait_req(got);
        checkOutput({name, " req"}, 64'(got), 64'd1);
        checkOutput({name, " addr"}, 64'(sdram_addr), 64'(exp_addr));
        pulse_ack();
        tick();
        pulse_rdy(d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        bit got;
        int n;
        bit seen;

        rst = 1'b1; downloading = 1'b0; cl_req = '0; cl_addr = '0;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        tick(); tick();
        checkOutput("reset sdram_req", 64'(sdram_req), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset cl_data", 64'(cl_data[63:0]), 64'd0);
        rst = 1'b0;
        tick();

        // single miss
        set_addr(1, 22'h00100);
        cl_req = 4'b0010;
        tick();
        checkOutput("single req latency", 64'(sdram_req), 64'd1);
        checkOutput("single addr", 64'(sdram_addr), 64'h00100);
        checkOutput("single busy", 64'(busy), 64'd1);
        tick();
        checkOutput("single req held", 64'(sdram_req), 64'd1);
        pulse_ack();
        checkOutput("single req drop", 64'(sdram_req), 64'd0);
        tick(); tick();
        checkOutput("single ok before rdy", 64'(cl_ok), 64'd0);
        pulse_rdy(32'hDEADBEEF);
        checkOutput("single data", 64'(data_of(1)), 64'hDEADBEEF);
        checkOutput("single ok", 64'(cl_ok), 64'b0010);
        checkOutput("single idle", 64'(busy), 64'd0);
        cl_req = '0;
        tick();
        cl_req = 4'b0010;
        #1;
        checkOutput("rehit ok", 64'(cl_ok), 64'b0010);
        tick();
        checkOutput("rehit no req", 64'(sdram_req), 64'd0);
        cl_req = '0;
        do_reset();

        // contention: all four miss at once, pointer at 0
        applyStimulus(4'hF, 22'h1000, 22'h1001, 22'h1002, 22'h1003);
        for (int i = 0; i < 4; i++)
            serve(22'h1000 + 22'(i), 32'hA5000000 | (32'h1000 + 32'(i)), $sformatf("rr order %0d", i));
        checkOutput("rr all ok", 64'(cl_ok), 64'hF);
        set_addr(0, 22'h2000);
        set_addr(2, 22'h2002);
        serve(22'h2000, 32'hA5002000, "rr second 0");
        serve(22'h2002, 32'hA5002002, "rr second 2");
        set_addr(0, 22'h3000);
        set_addr(3, 22'h3003);
        serve(22'h3003, 32'hA5003003, "rr wrap 3");
        serve(22'h3000, 32'hA5003000, "rr wrap 0");
        tick();
        checkOutput("rr quiet", 64'(sdram_req), 64'd0);
        checkOutput("rr data0", 64'(data_of(0)), 64'hA5003000);
        checkOutput("rr data1", 64'(data_of(1)), 64'hA5001001);
        checkOutput("rr data2", 64'(data_of(2)), 64'hA5002002);
        checkOutput("rr data3", 64'(data_of(3)), 64'hA5003003);
        cl_req = '0;
        tick();

        // hit table against caches {3000,1001,2002,3003}
        vecs[0] = '{4'hF, 22'h3000, 22'h1001, 22'h2002, 22'h3003, 4'hF};
        vecs[1] = '{4'h5, 22'h3000, 22'h1001, 22'h2002, 22'h3003, 4'h5};
        vecs[2] = '{4'hF, 22'h3000, 22'h1002, 22'h2002, 22'h3003, 4'hD};
        vecs[3] = '{4'hF, 22'h3001, 22'h1001, 22'h2002, 22'h3003, 4'hE};
        vecs[4] = '{4'h0, 22'h3000, 22'h1001, 22'h2002, 22'h3003, 4'h0};
        vecs[5] = '{4'h8, 22'h0000, 22'h0000, 22'h0000, 22'h3003, 4'h8};
        vecs[6] = '{4'hF, 22'h1001, 22'h3000, 22'h3003, 22'h2002, 4'h0};
        vecs[7] = '{4'hA, 22'h3000, 22'h1001, 22'h2000, 22'h3003, 4'hA};
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].req, vecs[v].a0, vecs[v].a1, vecs[v].a2, vecs[v].a3);
            #1;
            checkOutput($sformatf("hit vec %0d", v), 64'(cl_ok), 64'(vecs[v].exp_ok));
            cl_req = '0;
            tick();
        end
        checkOutput("hit table no req", 64'(sdram_req), 64'd0);

        // timeout and re-issue
        set_addr(1, 22'h00055);
        cl_req = 4'b0010;
        wait_req(got);
        checkOutput("tout first req", 64'(got), 64'd1);
        pulse_ack();
        n = 0;
        while (!sdram_req && n < 400) begin
            tick();
            n++;
        end
        checkOutput("tout cycles", 64'(n), 64'(TOUT));
        checkOutput("tout addr", 64'(sdram_addr), 64'h00055);
        checkOutput("tout busy", 64'(busy), 64'd1);
        pulse_ack();
        tick();
        pulse_rdy(32'h12345678);
        checkOutput("tout ok", 64'(cl_ok), 64'b0010);
        checkOutput("tout data", 64'(data_of(1)), 64'h12345678);
        cl_req = '0;
        tick();

        // address change while in flight
        set_addr(2, 22'h10);
        cl_req = 4'b0100;
        wait_req(got);
        checkOutput("move first addr", 64'(sdram_addr), 64'h10);
        pulse_ack();
        set_addr(2, 22'h20);
        tick();
        pulse_rdy(32'h11111111);
        checkOutput("move ok low", 64'(cl_ok), 64'd0);
        serve(22'h20, 32'h22222222, "move reissue");
        checkOutput("move ok", 64'(cl_ok), 64'b0100);
        checkOutput("move data", 64'(data_of(2)), 64'h22222222);

        // download with a transaction in flight
        cl_req = 4'b0110;
        #1;
        checkOutput("dl pre ok", 64'(cl_ok), 64'b0110);
        set_addr(0, 22'h777);
        cl_req = 4'b0111;
        wait_req(got);
        checkOutput("dl inflight addr", 64'(sdram_addr), 64'h777);
        pulse_ack();
        downloading = 1'b1;
        tick();
        checkOutput("dl ok drop", 64'(cl_ok), 64'd0);
        pulse_rdy(32'h99999999);
        checkOutput("dl no cache", 64'(cl_ok), 64'd0);
        checkOutput("dl idle", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (sdram_req) seen = 1'b1;
            tick();
        end
        checkOutput("dl no grant", 64'(seen), 64'd0);
        downloading = 1'b0;
        wait_req(got);
        checkOutput("dl resume req", 64'(got), 64'd1);
        checkOutput("dl resume addr", 64'(sdram_addr), 64'h00055);

        // asynchronous reset in WAIT_ACK
        rst = 1'b1;
        #1;
        checkOutput("arst req", 64'(sdram_req), 64'd0);
        checkOutput("arst busy", 64'(busy), 64'd0);
        checkOutput("arst ok", 64'(cl_ok), 64'd0);
        cl_req = '0;
        tick();
        rst = 1'b0;
        tick();
        applyStimulus(4'b1001, 22'h400, 22'h0, 22'h0, 22'h403);
        wait_req(got);
        checkOutput("arst ptr grant", 64'(sdram_addr), 64'h400);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
